// File: rtl/udcounter_ctrl_pkg.sv
// udcounter_ctrl_pkg
//   Shared definitions for the udcounter board-side command front end:
//   run-state encoding, state width, default debounce settings and the
//   next-state function used by the run/pause controller.

package udcounter_ctrl_pkg;

   localparam int STATE_W             = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz
   localparam int DB_W_DEF            = 20;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_PAUSE   = 2'b10,
      ST_ILLEGAL = 2'b11
   } run_state_e;

   // Next run state from the current state and the debounced rise pulses.
   // A simultaneous start/stop rise leaves IDLE alone, pauses a running
   // counter (stop wins) and resumes a paused one.
   function automatic run_state_e next_run_state(input run_state_e cur,
                                                 input logic       start_rise,
                                                 input logic       stop_rise);
      run_state_e nxt;
      nxt = cur;
      case (cur)
         ST_IDLE:  if (start_rise && !stop_rise) nxt = ST_RUN;
         ST_RUN:   if (stop_rise)                nxt = ST_PAUSE;
         ST_PAUSE: if (start_rise || stop_rise)  nxt = ST_RUN;
         default:                                nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchroniser, stability debouncer and rise detector for one
//   raw board input.
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-low reset
//     raw    in   asynchronous raw input
//     level  out  debounced level
//     rise   out  single-cycle pulse on each accepted 0->1 change of level
//
//   The debounced level only follows the synchronised input once it has
//   differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to
//   the current level restarts the count.

import udcounter_ctrl_pkg::*;

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int DB_W            = DB_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [DB_W-1:0] CNT_TC = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            level_q;
   logic            level_d;
   logic            level_prev_q;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + DB_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         cnt_q        <= cnt_d;
      end
   end

   assign level = level_q;
   // Both terms clear together on reset, so no pulse can appear on release.
   assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/udcounter_ctrl.sv
// udcounter_ctrl
//   Board-side command front end for udcounter. Debounces the push buttons
//   and direction switch and turns them into the counter's command inputs.
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   asynchronous, active-low reset
//     btn_start  in   raw start button, active-high
//     btn_stop   in   raw stop button, active-high
//     btn_load   in   raw load button, active-high
//     sw_updown  in   raw direction switch, 1 = up
//     start      out  start level to udcounter
//     stop       out  stop (pause) level to udcounter
//     load       out  one-cycle load pulse to udcounter
//     updown     out  debounced direction level
//     run_state  out  current run state, for LEDs
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_IDLE  | counter not started, start=0 stop=0
//   ST_RUN   | counting, start=1 stop=0
//   ST_PAUSE | paused by stop, start=1 stop=1
//   11       | unreachable; recovers to ST_IDLE next clock

import udcounter_ctrl_pkg::*;

module udcounter_ctrl #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int DB_W            = DB_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_start,
   input  logic               btn_stop,
   input  logic               btn_load,
   input  logic               sw_updown,
   output logic               start,
   output logic               stop,
   output logic               load,
   output logic               updown,
   output logic [STATE_W-1:0] run_state
);

   logic start_rise;
   logic stop_rise;
   logic load_rise;
   logic updown_lvl;
   logic start_lvl_unused;
   logic stop_lvl_unused;
   logic load_lvl_unused;
   logic updown_rise_unused;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_start (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_start),
      .level (start_lvl_unused),
      .rise  (start_rise)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_stop (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_stop),
      .level (stop_lvl_unused),
      .rise  (stop_rise)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_load (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_load),
      .level (load_lvl_unused),
      .rise  (load_rise)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_updown (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_updown),
      .level (updown_lvl),
      .rise  (updown_rise_unused)
   );

   run_state_e state_q;
   run_state_e state_d;
   logic       start_q;
   logic       start_d;
   logic       stop_q;
   logic       stop_d;
   logic       load_q;
   logic       load_d;
   logic       updown_q;
   logic       updown_d;

   // Outputs are decoded from the next state so they change in the same
   // cycle as run_state, one clock after the debounced rise.
   always_comb begin
      state_d  = next_run_state(state_q, start_rise, stop_rise);
      start_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
      stop_d   = (state_d == ST_PAUSE);
      load_d   = load_rise;
      updown_d = updown_lvl;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
         load_q   <= 1'b0;
         updown_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         load_q   <= load_d;
         updown_q <= updown_d;
      end
   end

   assign start     = start_q;
   assign stop      = stop_q;
   assign load      = load_q;
   assign updown    = updown_q;
   assign run_state = state_q;

endmodule

// File: doc/udcounter_ctrl.md
Name: udcounter_ctrl

Overview:
Board-side command front end for the up/down counter (udcounter).
- Takes raw push buttons and a slide switch from the Spartan-6 edge board.
- Synchronises and debounces them, then produces the counter's command inputs: start/stop levels, a single-cycle load pulse and an updown level.
- Sits between the board I/O pins and udcounter, and drives the same signals the counter bench drives by hand.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a raw input change is accepted (10 ms at 50 MHz).
- DB_W, 20, width of each debounce counter; must satisfy 2**DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_start  input  1  raw start push button, asynchronous, active-high.
- btn_stop  input  1  raw stop push button, asynchronous, active-high.
- btn_load  input  1  raw load push button, asynchronous, active-high.
- sw_updown  input  1  raw direction slide switch, asynchronous; 1 = up.
- start  output  1  level to udcounter start.
- stop  output  1  level to udcounter stop (pause interrupt).
- load  output  1  one-cycle pulse to udcounter load.
- updown  output  1  debounced direction level to udcounter updown.
- run_state  output  2  current FSM state, for LEDs.

Behaviour:
- Reset (reset=0, asynchronous): start=0, stop=0, load=0, updown=0, run_state=IDLE. All synchronisers, debounced values, debounce counters and edge registers clear to 0. This applies equally mid-debounce or mid-pulse; no pulse may be emitted on reset release.
- Synchroniser: each raw input passes through 2 flops. The synchronised value is s.
- Debounce, per input, with debounced value d and counter c:
  - If s==d, then c<=0.
  - Else, if c==DEBOUNCE_CYCLES-1, then d<=s and c<=0.
  - Else c<=c+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes d.
- Rise detect: r = d & ~d_prev, where d_prev is d registered once. r is a single clk cycle.
- Latency: a clean raw step becomes visible in d after 2 + DEBOUNCE_CYCLES cycles. Any rise-derived output changes 1 cycle later (registered outputs).
- load: registered copy of the load rise. High exactly 1 cycle per accepted press, in every FSM state. A held button gives no repeat.
- updown: registered copy of d(sw_updown). It is a level, independent of FSM state.
- FSM (registered Moore outputs). Encoding: IDLE=00 (start=0, stop=0), RUN=01 (start=1, stop=0), PAUSE=10 (start=1, stop=1).
  - IDLE: start rise -> RUN; stop rise ignored.
  - RUN: stop rise -> PAUSE; start rise ignored.
  - PAUSE: start rise or stop rise -> RUN.
  - Simultaneous start and stop rise in the same cycle: IDLE -> IDLE; RUN -> PAUSE (stop wins); PAUSE -> RUN.
  - Encoding 11 is illegal and returns to IDLE on the next clock.
- Load has no effect on FSM state. A load rise coinciding with a state change produces both effects in the same cycle.

Decomposition:
- Package udcounter_ctrl_pkg holds the state encodings IDLE/RUN/PAUSE, the 2-bit state width and the default DEBOUNCE_CYCLES.
- One natural sub-module: btn_debounce (2-flop sync + debounce counter + rise pulse; ports clk, reset, raw, level, rise; parameters DEBOUNCE_CYCLES, DB_W). It is instantiated 4 times; udcounter_ctrl contains only the FSM and output registers.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, 10 ns clock.
1. Reset with all raw inputs 0, then hold btn_start=1 for 10 cycles -> start rises exactly 7 cycles after the raw edge (2 sync + 4 debounce + 1 output register); run_state=01; stop=0; load never pulses.
2. In RUN, apply a 3-cycle pulse on btn_stop -> no change. Then hold btn_stop for 10 cycles -> stop=1, run_state=10. Release, then press btn_stop again -> run_state=01, stop=0.
3. btn_load held 50 cycles in each of IDLE, RUN and PAUSE -> exactly one 1-cycle load pulse per press; run_state unchanged.
4. btn_start and btn_stop raised on the same raw cycle in each state -> IDLE stays 00, RUN goes to 10, PAUSE goes to 01.
5. Toggle sw_updown 0->1 -> updown=1 after 7 cycles. Chatter the switch at 2-cycle period for 20 cycles -> updown holds its last stable value.
6. Assert reset low asynchronously while in PAUSE with a debounce in progress on btn_load -> all outputs 0 and run_state=00 immediately without waiting for a clock. After release, no load pulse and no state change until a fresh 4-cycle-stable press.
